// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Upstream command stage for the ALU. Takes one operation per
//            cmd valid/ready handshake, serialises operands A, B and an
//            optional D onto the shared ALU data bus with WA/WB/WD strobes,
//            waits for FINP (with a watchdog), reads R1/R2/FLAGS through WR
//            and returns them on a res valid/ready handshake.
// Ports    : CLK, RST (sync, active-low)
//            cmd_valid/cmd_ready, cmd_op, cmd_a, cmd_b, cmd_d, cmd_use_d
//            alu_A, alu_op, alu_WA, alu_WB, alu_WD, alu_WR  (to ALU)
//            alu_R1, alu_R2, alu_FLAGS, alu_FINP            (from ALU)
//            res_valid/res_ready, res_r1, res_r2, res_flags, res_timeout
// Revision : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter int DW         = 16,
  parameter int OPW        = 6,
  parameter int STROBE_CYC = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_op,
  input  logic [DW-1:0]  cmd_a,
  input  logic [DW-1:0]  cmd_b,
  input  logic [DW-1:0]  cmd_d,
  input  logic           cmd_use_d,
  output logic [DW-1:0]  alu_A,
  output logic [OPW-1:0] alu_op,
  output logic           alu_WA,
  output logic           alu_WB,
  output logic           alu_WD,
  output logic [1:0]     alu_WR,
  input  logic [DW-1:0]  alu_R1,
  input  logic [DW-1:0]  alu_R2,
  input  logic [DW-1:0]  alu_FLAGS,
  input  logic           alu_FINP,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [DW-1:0]  res_r1,
  output logic [DW-1:0]  res_r2,
  output logic [DW-1:0]  res_flags,
  output logic           res_timeout
);

  localparam int SCW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [SCW-1:0] STROBE_LAST = SCW'(STROBE_CYC - 1);
  localparam logic [TW-1:0]  WAIT_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]  WAIT_MAX    = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_A     = 3'd1,
    S_LD_B     = 3'd2,
    S_LD_D     = 3'd3,
    S_WAIT_FIN = 3'd4,
    S_READ     = 3'd5,
    S_RESP     = 3'd6
  } state_t;

  state_t          state;
  logic [DW-1:0]   b_q;
  logic [DW-1:0]   d_q;
  logic            use_d_q;
  logic [SCW-1:0]  strobe_cnt;
  logic [TW-1:0]   wait_cnt;
  logic            read_2nd;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      alu_A       <= '0;
      alu_op      <= '0;
      alu_WA      <= 1'b0;
      alu_WB      <= 1'b0;
      alu_WD      <= 1'b0;
      alu_WR      <= 2'b00;
      res_valid   <= 1'b0;
      res_r1      <= '0;
      res_r2      <= '0;
      res_flags   <= '0;
      res_timeout <= 1'b0;
      b_q         <= '0;
      d_q         <= '0;
      use_d_q     <= 1'b0;
      strobe_cnt  <= '0;
      wait_cnt    <= '0;
      read_2nd    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            // Operand A goes straight onto the bus; B/D wait in holding regs.
            b_q        <= cmd_b;
            d_q        <= cmd_d;
            use_d_q    <= cmd_use_d;
            alu_op     <= cmd_op;
            alu_A      <= cmd_a;
            alu_WA     <= 1'b1;
            cmd_ready  <= 1'b0;
            strobe_cnt <= '0;
            state      <= S_LD_A;
          end
        end

        S_LD_A: begin
          if (strobe_cnt == STROBE_LAST) begin
            strobe_cnt <= '0;
            alu_WA     <= 1'b0;
            alu_WB     <= 1'b1;
            alu_A      <= b_q;
            state      <= S_LD_B;
          end else begin
            strobe_cnt <= strobe_cnt + SCW'(1);
          end
        end

        S_LD_B: begin
          if (strobe_cnt == STROBE_LAST) begin
            strobe_cnt <= '0;
            alu_WB     <= 1'b0;
            if (use_d_q) begin
              alu_WD <= 1'b1;
              alu_A  <= d_q;
              state  <= S_LD_D;
            end else begin
              alu_A    <= '0;
              wait_cnt <= '0;
              state    <= S_WAIT_FIN;
            end
          end else begin
            strobe_cnt <= strobe_cnt + SCW'(1);
          end
        end

        S_LD_D: begin
          if (strobe_cnt == STROBE_LAST) begin
            strobe_cnt <= '0;
            alu_WD     <= 1'b0;
            alu_A      <= '0;
            wait_cnt   <= '0;
            state      <= S_WAIT_FIN;
          end else begin
            strobe_cnt <= strobe_cnt + SCW'(1);
          end
        end

        S_WAIT_FIN: begin
          // FINP is tested before the watchdog so a finish on the final
          // counted cycle still produces a real result.
          if (alu_FINP) begin
            alu_WR   <= 2'b11;
            read_2nd <= 1'b0;
            state    <= S_READ;
          end else if (wait_cnt == WAIT_LAST) begin
            alu_op      <= '0;
            res_valid   <= 1'b1;
            res_timeout <= 1'b1;
            res_r1      <= '0;
            res_r2      <= '0;
            res_flags   <= '0;
            state       <= S_RESP;
          end
          if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end

        S_READ: begin
          if (!read_2nd) begin
            read_2nd <= 1'b1;
          end else begin
            res_r1      <= alu_R1;
            res_r2      <= alu_R2;
            res_flags   <= alu_FLAGS;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            alu_WR      <= 2'b00;
            alu_op      <= '0;
            state       <= S_RESP;
          end
        end

        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Self-checking bench for alu_cmd_sequencer. A behavioural ALU
//            model answers the bus; directed vectors from a table carry the
//            hand-computed results and latencies, and short hand-written
//            sequences cover result back-pressure and mid-operation reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  localparam int S = 2;
  localparam int T = 255;

  logic        CLK, RST;
  logic        cmd_valid, cmd_ready, cmd_use_d;
  logic [5:0]  cmd_op, alu_op;
  logic [15:0] cmd_a, cmd_b, cmd_d, alu_A;
  logic        alu_WA, alu_WB, alu_WD, alu_FINP;
  logic [1:0]  alu_WR;
  logic [15:0] alu_R1, alu_R2, alu_FLAGS;
  logic        res_valid, res_ready, res_timeout;
  logic [15:0] res_r1, res_r2, res_flags;

  alu_cmd_sequencer #(.DW(16), .OPW(6), .STROBE_CYC(S), .TIMEOUT(T)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_use_d(cmd_use_d),
    .alu_A(alu_A), .alu_op(alu_op), .alu_WA(alu_WA), .alu_WB(alu_WB),
    .alu_WD(alu_WD), .alu_WR(alu_WR), .alu_R1(alu_R1), .alu_R2(alu_R2),
    .alu_FLAGS(alu_FLAGS), .alu_FINP(alu_FINP),
    .res_valid(res_valid), .res_ready(res_ready), .res_r1(res_r1),
    .res_r2(res_r2), .res_flags(res_flags), .res_timeout(res_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural ALU model ----------------
  // mode 0: FINP 3 cycles after the last strobe; 1: never; 2: always high.
  int          mode = 0;
  logic        use_d_m = 1'b0;
  logic [15:0] ma, mb, md;
  logic [5:0]  mop;
  logic        last_prev;
  int          dly;
  logic [16:0] sum;

  always @(posedge CLK) begin
    if (!RST) begin
      last_prev <= 1'b0;
      dly       <= 0;
      alu_FINP  <= 1'b0;
    end else begin
      if (alu_WA) begin ma <= alu_A; mop <= alu_op; end
      if (alu_WB) mb <= alu_A;
      if (alu_WD) md <= alu_A;
      last_prev <= use_d_m ? alu_WD : alu_WB;
      if (last_prev && !(use_d_m ? alu_WD : alu_WB)) dly <= 2;
      else if (dly != 0) dly <= dly - 1;
      if (mode == 1) alu_FINP <= 1'b0;
      else if (alu_WR == 2'b11) alu_FINP <= 1'b0;
      else if (mode == 2 || dly == 1) alu_FINP <= 1'b1;
    end
  end

  always_comb begin
    sum       = {1'b0, ma} + {1'b0, mb};
    alu_R1    = '0;
    alu_R2    = '0;
    alu_FLAGS = '0;
    case (mop)
      6'd0: begin alu_R1 = sum[15:0]; alu_FLAGS[0] = sum[16]; end
      6'd5: begin alu_R1 = ma - mb; alu_FLAGS[0] = (ma < mb); end
      6'h25: if (md != 0) begin alu_R1 = ma / md; alu_R2 = ma % md; end
      default: ;
    endcase
    alu_FLAGS[1] = (alu_R1 == 16'h0);
  end

  // ---------------- bus protocol monitor ----------------
  logic [5:0]  cur_op = '0;
  int          pv = 0;
  int          wa_tot = 0, wb_tot = 0, wd_tot = 0, wr_tot = 0;
  logic [15:0] wa_val, wb_val, wd_val, prev_A = '0;
  logic [2:0]  prev_str = '0;

  always @(negedge CLK) begin
    automatic int n = int'(alu_WA) + int'(alu_WB) + int'(alu_WD);
    if (n > 1) pv++;
    if (n == 0 && alu_A != 16'h0) pv++;
    if (n != 0 && alu_op != cur_op) pv++;
    if (alu_WR != 2'b00 && (alu_WR != 2'b11 || n != 0 || alu_op != cur_op)) pv++;
    if ({alu_WA, alu_WB, alu_WD} == prev_str && n != 0 && alu_A != prev_A) pv++;
    if (alu_WA) begin wa_tot++; wa_val = alu_A; end
    if (alu_WB) begin wb_tot++; wb_val = alu_A; end
    if (alu_WD) begin wd_tot++; wd_val = alu_A; end
    if (alu_WR == 2'b11) wr_tot++;
    prev_str = {alu_WA, alu_WB, alu_WD};
    prev_A   = alu_A;
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [5:0]  op;
    logic [15:0] a, b, d;
    logic        use_d;
    int          mode;
    logic [15:0] r1, r2, flags;
    logic        tmo;
    int          lat;
  } vec_t;

  vec_t vecs[5];
  int   wa0, wb0, wd0, wr0;

  task automatic start_cmd(input vec_t v);
    cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_d = v.d; cmd_use_d = v.use_d;
    cur_op = v.op; use_d_m = v.use_d; mode = v.mode;
    wa0 = wa_tot; wb0 = wb_tot; wd0 = wd_tot; wr0 = wr_tot;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int g = 0;
    while (!cmd_ready && g < 60) begin @(negedge CLK); g++; end
    if (!cmd_ready) chk({name, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
    else @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  // Edges from the accept edge to the edge that first samples res_valid=1.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!res_valid && lat < 700) begin @(negedge CLK); lat++; end
  endtask

  task automatic check_result(input string name, input vec_t v, input int lat);
    chk({name, "_latency"}, 32'(lat), 32'(v.lat));
    chk({name, "_r1"}, 32'(res_r1), 32'(v.r1));
    chk({name, "_r2"}, 32'(res_r2), 32'(v.r2));
    chk({name, "_flags"}, 32'(res_flags), 32'(v.flags));
    chk({name, "_timeout"}, 32'(res_timeout), 32'(v.tmo));
    chk({name, "_op_idle_in_resp"}, 32'(alu_op), 32'd0);
    chk({name, "_wa_cycles"}, 32'(wa_tot - wa0), 32'(S));
    chk({name, "_wa_data"}, 32'(wa_val), 32'(v.a));
    chk({name, "_wb_cycles"}, 32'(wb_tot - wb0), 32'(S));
    chk({name, "_wb_data"}, 32'(wb_val), 32'(v.b));
    chk({name, "_wd_cycles"}, 32'(wd_tot - wd0), v.use_d ? 32'(S) : 32'd0);
    if (v.use_d) chk({name, "_wd_data"}, 32'(wd_val), 32'(v.d));
    chk({name, "_wr_cycles"}, 32'(wr_tot - wr0), v.tmo ? 32'd0 : 32'd2);
  endtask

  task automatic handshake(input string name);
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    chk({name, "_valid_dropped"}, 32'(res_valid), 32'd0);
    chk({name, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    start_cmd(v);
    wait_accept(name);
    wait_result(lat);
    check_result(name, v, lat);
    handshake(name);
  endtask

  initial begin
    int   lat;
    logic ok;
    vecs[0] = '{6'd5,  16'hCD0D, 16'hCD3D, 16'h0000, 1'b0, 0, 16'hFFD0, 16'h0000, 16'h0001, 1'b0, 2*S+4+3};
    vecs[1] = '{6'd0,  16'h8000, 16'h8000, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000, 16'h0003, 1'b0, 2*S+4+3};
    vecs[2] = '{6'h25, 16'h0064, 16'h1234, 16'h000A, 1'b1, 0, 16'h000A, 16'h0000, 16'h0000, 1'b0, 3*S+4+3};
    vecs[3] = '{6'd0,  16'h1234, 16'h0001, 16'h0000, 1'b0, 2, 16'h1235, 16'h0000, 16'h0000, 1'b0, 2*S+1+3};
    vecs[4] = '{6'd5,  16'h1111, 16'h2222, 16'h0000, 1'b0, 1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2*S+T+1};

    RST = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_d = '0; cmd_use_d = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_strobes", 32'({alu_WA, alu_WB, alu_WD, alu_WR}), 32'd0);
    chk("rst_bus", 32'({alu_A, alu_op}), 32'd0);
    chk("rst_results", 32'({res_r1, res_r2}), 32'd0);
    chk("rst_flags_tmo", 32'({res_flags, res_timeout}), 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-pressure: result held while a second command waits.
    start_cmd(vecs[0]);
    wait_accept("bp");
    wait_result(lat);
    check_result("bp_first", vecs[0], lat);
    start_cmd(vecs[2]);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!res_valid || cmd_ready || res_r1 != 16'hFFD0 || res_r2 != 16'h0
          || res_flags != 16'h0001 || res_timeout) ok = 1'b0;
    end
    chk("bp_hold_stable", 32'(ok), 32'd1);
    handshake("bp");
    wait_accept("bp_second");
    wait_result(lat);
    check_result("bp_second", vecs[2], lat);
    handshake("bp_second");

    // Reset while operand B is being strobed.
    start_cmd(vecs[0]);
    wait_accept("rstmid");
    for (int g = 0; g < 20 && !alu_WB; g++) @(negedge CLK);
    chk("rstmid_reached_ld_b", 32'(alu_WB), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk("rstmid_wb_low", 32'(alu_WB), 32'd0);
    chk("rstmid_bus_zero", 32'(alu_A), 32'd0);
    chk("rstmid_op_zero", 32'(alu_op), 32'd0);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    RST = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) ok = 1'b0;
      @(negedge CLK);
    end
    chk("rstmid_no_result", 32'(ok), 32'd1);
    run_vec("after_rst", vecs[1]);

    chk("protocol_violations", 32'(pv), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
